// File: rtl/rtc_bus_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rtc_bus_sched_if                                               |
// | Purpose  : Signal bundle between the RTC requesters, the shared-access    |
// |            scheduler and the RTC multiplexed address/data pins.           |
// | Modports : master - the scheduler. It owns the grants, the completions    |
// |                     and the RTC pins.                                      |
// |            slave  - the requester side plus the RTC pad (ad_in).          |
// | Signals  : req/req_wr/req_addr/req_wdata  per-requester request fields     |
// |            gnt/done/rdata/busy            per-requester results           |
// |            cs_n/rd_n/wr_n/ad_n/ad_out/ad_oe/ad_in  RTC bus                 |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface rtc_bus_sched_if;
   // Requester side. Requester i uses bit i and byte lane [8i+7:8i].
   logic [2:0]  req;
   logic [2:0]  req_wr;
   logic [23:0] req_addr;
   logic [23:0] req_wdata;
   logic [2:0]  gnt;
   logic [2:0]  done;
   logic [7:0]  rdata;
   logic        busy;

   // RTC pin side. All strobes are active-low.
   logic        cs_n;
   logic        rd_n;
   logic        wr_n;
   logic        ad_n;
   logic [7:0]  ad_out;
   logic        ad_oe;
   logic [7:0]  ad_in;

   modport master (
      input  req, req_wr, req_addr, req_wdata, ad_in,
      output gnt, done, rdata, busy,
      output cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
   );

   modport slave (
      output req, req_wr, req_addr, req_wdata, ad_in,
      input  gnt, done, rdata, busy,
      input  cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
   );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rtc_bus_sched                                                  |
// | Purpose  : Shared-access scheduler and bus sequencer for the external    |
// |            RTC multiplexed address/data bus. Arbitrates between the init |
// |            sequencer (0), the while-true read loop (1) and the user      |
// |            write path (2). Each grant runs exactly one transaction:       |
// |            ADDR -> AHOLD -> DATA -> DHOLD, each TPH cycles long, then a   |
// |            one-cycle DONE pulse to the winner.                            |
// | Params   : TPH  cycles per bus phase, 1..255                              |
// | Ports    : CLK    system clock, rising edge                               |
// |            reset  asynchronous, active-low                                |
// |            bus    rtc_bus_sched_if.master (requests, grants, RTC pins)    |
// | Options  : RTC_SCHED_RR_EN  when defined, requesters 1 and 2 share the    |
// |            second priority level round-robin (2 first after reset).      |
// |            When undefined, the priority is fixed: 0 > 2 > 1.              |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rtc_bus_sched #(
   parameter int unsigned TPH = 10
) (
   input  logic            CLK,
   input  logic            reset,
   rtc_bus_sched_if.master bus
);

   // Terminal value of the phase counter in every timed state.
   localparam logic [7:0] c_last_cnt = 8'(TPH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      AHOLD = 3'd2,
      DATA  = 3'd3,
      DHOLD = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic        w_phase_end;

   // Latched transaction, frozen for the whole grant.
   logic [2:0]  r_gnt;
   logic        r_wr;
   logic [7:0]  r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_rdata;

   // Arbitration result for the current IDLE cycle.
   logic [2:0]  w_pick;
   logic        w_grant;
   logic        w_sel_wr;
   logic [7:0]  w_sel_addr;
   logic [7:0]  w_sel_wdata;

   // Decoded outputs.
   logic [2:0]  w_done;
   logic        w_cs_n;
   logic        w_rd_n;
   logic        w_wr_n;
   logic        w_ad_n;
   logic        w_ad_oe;
   logic [7:0]  w_ad_out;

   assign w_phase_end = (r_cnt == c_last_cnt);
   assign w_grant     = (r_state == IDLE) && (|bus.req);

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
`ifdef RTC_SCHED_RR_EN
   // r_pri2 = 1 means requester 2 wins a tie against requester 1. The
   // requester granted last among {1,2} drops to the lower position.
   logic r_pri2;

   always_comb begin
      w_pick = 3'b000;
      if (bus.req[0]) begin
         w_pick = 3'b001;
      end else if (bus.req[1] && bus.req[2]) begin
         w_pick = r_pri2 ? 3'b100 : 3'b010;
      end else if (bus.req[2]) begin
         w_pick = 3'b100;
      end else if (bus.req[1]) begin
         w_pick = 3'b010;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_pri2 <= 1'b1;
      end else if (w_grant) begin
         if (w_pick[1]) begin
            r_pri2 <= 1'b1;
         end else if (w_pick[2]) begin
            r_pri2 <= 1'b0;
         end
      end
   end
`else
   always_comb begin
      w_pick = 3'b000;
      if (bus.req[0]) begin
         w_pick = 3'b001;
      end else if (bus.req[2]) begin
         w_pick = 3'b100;
      end else if (bus.req[1]) begin
         w_pick = 3'b010;
      end
   end
`endif

   // Route the winner's request fields to the latch inputs.
   always_comb begin
      w_sel_wr    = bus.req_wr[2];
      w_sel_addr  = bus.req_addr[23:16];
      w_sel_wdata = bus.req_wdata[23:16];
      unique case (w_pick)
         3'b001: begin
            w_sel_wr    = bus.req_wr[0];
            w_sel_addr  = bus.req_addr[7:0];
            w_sel_wdata = bus.req_wdata[7:0];
         end
         3'b010: begin
            w_sel_wr    = bus.req_wr[1];
            w_sel_addr  = bus.req_addr[15:8];
            w_sel_wdata = bus.req_wdata[15:8];
         end
         default: begin
            w_sel_wr    = bus.req_wr[2];
            w_sel_addr  = bus.req_addr[23:16];
            w_sel_wdata = bus.req_wdata[23:16];
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Sequencer: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer: next state and pin decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 8'd1;
      w_done      = 3'b000;
      w_cs_n      = 1'b1;
      w_rd_n      = 1'b1;
      w_wr_n      = 1'b1;
      w_ad_n      = 1'b1;
      w_ad_oe     = 1'b0;
      w_ad_out    = 8'h00;

      unique case (r_state)
         IDLE: begin
            w_cnt_nxt = 8'd0;
            if (w_grant) begin
               w_state_nxt = ADDR;
            end
         end

         ADDR: begin
            // The address phase is strobed on wr_n with ad_n low.
            w_cs_n   = 1'b0;
            w_wr_n   = 1'b0;
            w_ad_n   = 1'b0;
            w_ad_oe  = 1'b1;
            w_ad_out = r_addr;
            if (w_phase_end) begin
               w_state_nxt = AHOLD;
               w_cnt_nxt   = 8'd0;
            end
         end

         AHOLD: begin
            // Keep the address on the bus after the strobe rises.
            w_ad_n   = 1'b0;
            w_ad_oe  = 1'b1;
            w_ad_out = r_addr;
            if (w_phase_end) begin
               w_state_nxt = DATA;
               w_cnt_nxt   = 8'd0;
            end
         end

         DATA: begin
            w_cs_n = 1'b0;
            if (r_wr) begin
               w_wr_n   = 1'b0;
               w_ad_oe  = 1'b1;
               w_ad_out = r_wdata;
            end else begin
               // Pad released while the RTC drives the bus.
               w_rd_n = 1'b0;
            end
            if (w_phase_end) begin
               w_state_nxt = DHOLD;
               w_cnt_nxt   = 8'd0;
            end
         end

         DHOLD: begin
            if (w_phase_end) begin
               w_state_nxt = DONE;
               w_cnt_nxt   = 8'd0;
            end
         end

         DONE: begin
            w_done      = r_gnt;
            w_state_nxt = IDLE;
            w_cnt_nxt   = 8'd0;
         end

         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Transaction latch and read capture
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_gnt   <= 3'b000;
         r_wr    <= 1'b0;
         r_addr  <= 8'h00;
         r_wdata <= 8'h00;
         r_rdata <= 8'h00;
      end else begin
         if (w_grant) begin
            r_gnt   <= w_pick;
            r_wr    <= w_sel_wr;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
         end else if (r_state == DONE) begin
            r_gnt   <= 3'b000;
         end

         // Sample on the edge that closes the last read-data cycle.
         if ((r_state == DATA) && w_phase_end && !r_wr) begin
            r_rdata <= bus.ad_in;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.gnt    = r_gnt;
   assign bus.done   = w_done;
   assign bus.rdata  = r_rdata;
   assign bus.busy   = (r_state != IDLE);
   assign bus.cs_n   = w_cs_n;
   assign bus.rd_n   = w_rd_n;
   assign bus.wr_n   = w_wr_n;
   assign bus.ad_n   = w_ad_n;
   assign bus.ad_oe  = w_ad_oe;
   assign bus.ad_out = w_ad_out;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rtc_bus_sched                                               |
// | Purpose  : Self-checking bench for rtc_bus_sched. A transaction-timeline  |
// |            model predicts every output each cycle; directed sequences    |
// |            pin the model with literal expectations, then a randomized    |
// |            request stream runs against the model.                        |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_rtc_bus_sched;
   localparam int unsigned TPH = 2;

   logic CLK = 1'b0;
   logic reset = 1'b1;
   rtc_bus_sched_if bus ();

   rtc_bus_sched #(.TPH(TPH)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int n_check = 0;
   int n_pass  = 0;
   bit cmp_on  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_check++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
   endtask

   // ---------------- behavioural model: transaction timeline ----------------
   // m_t counts cycles since the grant; phase = m_t / TPH selects
   // address, address hold, data, data hold, then the done cycle.
   bit          m_busy  = 1'b0;
   int unsigned m_t     = 0;
   int          m_win   = 0;
   bit          m_wr    = 1'b0;
   logic [7:0]  m_addr  = 8'h00;
   logic [7:0]  m_wdata = 8'h00;
   logic [7:0]  m_rdata = 8'h00;
   bit          m_pri2  = 1'b1;

   function automatic int pick(input logic [2:0] r, input bit pri2);
      if (r[0]) return 0;
`ifdef RTC_SCHED_RR_EN
      if (r[1] && r[2]) return pri2 ? 2 : 1;
`else
      if (r[1] && r[2] && (pri2 || !pri2)) return 2;
`endif
      if (r[2]) return 2;
      return 1;
   endfunction

   always @(posedge CLK or negedge reset) begin
      if (!reset) begin
         m_busy  = 1'b0;
         m_t     = 0;
         m_rdata = 8'h00;
         m_pri2  = 1'b1;
      end else if (!m_busy) begin
         if (bus.req != 3'b000) begin
            m_win   = pick(bus.req, m_pri2);
            m_wr    = bus.req_wr[m_win];
            m_addr  = bus.req_addr[8*m_win +: 8];
            m_wdata = bus.req_wdata[8*m_win +: 8];
            if (m_win == 1) m_pri2 = 1'b1;
            if (m_win == 2) m_pri2 = 1'b0;
            m_busy  = 1'b1;
            m_t     = 0;
         end
      end else begin
         if (m_t == 3*TPH - 1 && !m_wr) m_rdata = bus.ad_in;
         if (m_t == 4*TPH) m_busy = 1'b0;
         else m_t++;
      end
   end

   // ---------------- per-cycle compare + protocol checks ----------------
   always @(negedge CLK) begin
      int unsigned ph;
      logic [2:0]  eg, ed;
      logic        ecs, erd, ewr, ead, eoe;
      logic [7:0]  eout, aout;
      if (cmp_on) begin
         ph   = m_t / TPH;
         eg   = m_busy ? (3'b001 << m_win) : 3'b000;
         ed   = (m_busy && ph == 4) ? eg : 3'b000;
         ecs  = !(m_busy && (ph == 0 || ph == 2));
         ewr  = !(m_busy && (ph == 0 || (ph == 2 && m_wr)));
         erd  = !(m_busy && ph == 2 && !m_wr);
         ead  = !(m_busy && ph <= 1);
         eoe  = m_busy && (ph <= 1 || (ph == 2 && m_wr));
         eout = eoe ? ((ph <= 1) ? m_addr : m_wdata) : 8'h00;
         aout = eoe ? bus.ad_out : 8'h00;
         chk("cycle_outputs",
             {4'h0, bus.gnt, bus.done, bus.busy, bus.cs_n, bus.rd_n, bus.wr_n,
              bus.ad_n, bus.ad_oe, aout, bus.rdata},
             {4'h0, eg, ed, m_busy, ecs, erd, ewr, ead, eoe, eout, m_rdata});
         chk("proto_rd_wr_overlap", {31'd0, !(bus.rd_n == 1'b0 && bus.wr_n == 1'b0)}, 32'd1);
         chk("proto_oe_during_rd", {31'd0, !(bus.ad_oe && bus.rd_n == 1'b0)}, 32'd1);
         chk("proto_gnt_onehot0", {31'd0, $onehot0(bus.gnt)}, 32'd1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_gnt(output logic [2:0] g);
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (bus.gnt != 3'b000) break;
      end
      g = bus.gnt;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (!bus.busy) break;
         tick(1);
      end
      if (bus.busy) chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] g;
      bus.req = 3'b000; bus.req_wr = 3'b000;
      bus.req_addr = 24'h0; bus.req_wdata = 24'h0; bus.ad_in = 8'h00;
      #1 reset = 1'b0;
      cmp_on = 1'b1;
      tick(3);
      // reset state
      chk("rst_gnt", {29'd0, bus.gnt}, 32'd0);
      chk("rst_done_busy", {28'd0, bus.done, bus.busy}, 32'd0);
      chk("rst_strobes", {27'd0, bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_n, bus.ad_oe}, 32'h1E);
      chk("rst_ad_out_rdata", {16'd0, bus.ad_out, bus.rdata}, 32'd0);
      reset = 1'b1;
      tick(1);

      // single write by user
      bus.req_wr = 3'b100; bus.req_addr = 24'h21_0000; bus.req_wdata = 24'h45_0000;
      bus.req = 3'b100;
      tick(1);
      chk("wr_gnt", {29'd0, bus.gnt}, 32'h4);
      chk("wr_addr_phase", {21'd0, bus.ad_n, bus.wr_n, bus.ad_oe, bus.ad_out}, {21'd0, 3'b001, 8'h21});
      bus.req = 3'b000;
      tick(1);
      chk("wr_addr_phase2", {23'd0, bus.ad_n, bus.ad_out}, {23'd0, 1'b0, 8'h21});
      tick(3);
      chk("wr_data_phase", {21'd0, bus.ad_n, bus.wr_n, bus.ad_oe, bus.ad_out}, {21'd0, 3'b101, 8'h45});
      tick(4);
      chk("wr_done", {29'd0, bus.done}, 32'h4);
      tick(1);
      chk("wr_idle", {28'd0, bus.gnt, bus.busy}, 32'd0);

      // single read by while-true loop
      bus.req_wr = 3'b000; bus.req_addr = 24'h00_2200; bus.ad_in = 8'h37;
      bus.req = 3'b010;
      tick(1);
      chk("rd_gnt", {29'd0, bus.gnt}, 32'h2);
      bus.req = 3'b000;
      tick(4);
      chk("rd_data_phase", {29'd0, bus.rd_n, bus.wr_n, bus.ad_oe}, 32'h2);
      tick(4);
      chk("rd_done", {29'd0, bus.done}, 32'h2);
      chk("rd_rdata", {24'd0, bus.rdata}, 32'h37);
      tick(1);

      // contention, all three at once
      bus.req = 3'b111;
      wait_gnt(g); chk("cont_first", {29'd0, g}, 32'h1);
      bus.req[0] = 1'b0; wait_idle();
      wait_gnt(g); chk("cont_second", {29'd0, g}, 32'h4);
      bus.req[2] = 1'b0; wait_idle();
      wait_gnt(g); chk("cont_third", {29'd0, g}, 32'h2);
      bus.req = 3'b000; wait_idle();

      // 1 and 2 held continuously
      bus.req = 3'b110;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(g);
`ifdef RTC_SCHED_RR_EN
         chk("hold12_order", {29'd0, g}, (i % 2 == 0) ? 32'h4 : 32'h2);
`else
         chk("hold12_order", {29'd0, g}, 32'h4);
`endif
         wait_idle();
      end
      bus.req = 3'b000; wait_idle();
      tick(1);

      // request dropped during address hold
      bus.req = 3'b010;
      tick(1);
      chk("drop_gnt", {29'd0, bus.gnt}, 32'h2);
      tick(2);
      bus.req = 3'b000;
      tick(6);
      chk("drop_done", {29'd0, bus.done}, 32'h2);
      tick(10);
      chk("drop_no_regrant", {28'd0, bus.gnt, bus.busy}, 32'd0);

      // reset during the data phase of a write
      bus.req_wr = 3'b001; bus.req_addr = 24'h00_005A; bus.req_wdata = 24'h00_00A5;
      bus.req = 3'b001;
      tick(1);
      bus.req = 3'b000;
      tick(4);
      chk("rst_mid_pre", {22'd0, bus.wr_n, bus.ad_oe, bus.ad_out}, {22'd0, 2'b01, 8'hA5});
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_strobes", {29'd0, bus.cs_n, bus.wr_n, bus.ad_oe}, 32'h6);
      chk("rst_mid_gnt_done", {25'd0, bus.gnt, bus.done, bus.busy}, 32'd0);
      chk("rst_mid_rdata", {24'd0, bus.rdata}, 32'd0);
      tick(2);
      reset = 1'b1;
      tick(1);
      bus.req_wr = 3'b100; bus.req = 3'b100;
      tick(1);
      chk("rst_restart_gnt", {29'd0, bus.gnt}, 32'h4);
      bus.req = 3'b000;
      tick(8);
      chk("rst_restart_done", {29'd0, bus.done}, 32'h4);
      tick(1);

      // randomized request stream
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 7) == 0) bus.req[b] = ~bus.req[b];
         bus.req_wr    = 3'($urandom);
         bus.req_addr  = 24'($urandom);
         bus.req_wdata = 24'($urandom);
         bus.ad_in     = 8'($urandom);
         tick(1);
      end
      bus.req = 3'b000;
      wait_idle();
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/rtc_bus_sched.md
# rtc_bus_sched

Shared-access scheduler and bus sequencer for the external RTC's multiplexed address/data bus. It arbitrates between three requesters: the initialization sequencer, the periodic while-true read loop and the user-control write path. It runs one complete address-phase/data-phase transaction per grant and returns read data with a one-cycle done pulse. It sits between the main RTC control FSM's sub-blocks and the RTC pins, so only one agent ever drives the bus.

## Interface
Parameters:
- TPH, 10, cycles per bus phase (1..255); 10 = 100 ns at 100 MHz

Ports:
- CLK  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- req  in  3  request per requester: [0] init, [1] while-true, [2] user
- req_wr  in  3  per requester: 1 = write, 0 = read
- req_addr  in  24  per requester RTC register address, requester i at [8i+7:8i]
- req_wdata  in  24  per requester write data, same packing
- gnt  out  3  one-hot grant, held for the whole transaction
- done  out  3  one-cycle completion pulse to the granted requester
- rdata  out  8  read data, valid while done is high, held until next read completes
- busy  out  1  high from grant until the end of DONE
- cs_n, rd_n, wr_n, ad_n  out  1 each  RTC strobes, all active-low; ad_n=0 marks address phase
- ad_out  out  8  bus drive value
- ad_oe  out  1  tristate enable for ad_out
- ad_in  in  8  bus sampled value

## Operation
- States: IDLE, ADDR, AHOLD, DATA, DHOLD, DONE. A phase counter (8 bit) counts 0..TPH-1 in each timed state.
- IDLE: all strobes 1, ad_oe=0, gnt=0. If any req bit is set, pick the winner, latch its wr/addr/wdata, set gnt, go to ADDR, clear the counter.
- ADDR: cs_n=0, wr_n=0, ad_n=0, ad_oe=1, ad_out=addr. Lasts TPH cycles.
- AHOLD: cs_n=wr_n=1, ad_n=0, ad_out/ad_oe held. Lasts TPH cycles.
- DATA, write: cs_n=0, wr_n=0, ad_n=1, ad_oe=1, ad_out=wdata.
- DATA, read: cs_n=0, rd_n=0, ad_n=1, ad_oe=0. rdata is captured from ad_in on the edge ending the last DATA cycle.
- DATA lasts TPH cycles.
- DHOLD: all strobes 1, ad_n=1, ad_oe=0. Lasts TPH cycles.
- DONE: done[winner]=1 for exactly one cycle, gnt still set. Then IDLE with gnt cleared.
- Priority (default): init(0) > user(2) > while-true(1). Fixed, no preemption.
- req, addr and data changes after the grant are ignored. Dropping req mid-transaction does not abort it.
- A requester still asserting req in IDLE after its DONE competes again normally. There are no back-to-back grants without one IDLE cycle.
- rd_n and wr_n are never low together. ad_oe is never 1 while rd_n=0.

## Timing
- Reset values: gnt=0, done=0, rdata=0, busy=0, cs_n=rd_n=wr_n=ad_n=1, ad_oe=0, ad_out=0; state IDLE, counter 0.
- Grant latency: req seen in IDLE cycle N gives gnt/busy high in cycle N+1.
- Done: gnt rises in cycle G, done is high in cycle G+4·TPH, IDLE is reached in G+4·TPH+1.
- Minimum request-to-request spacing is 4·TPH+2 cycles.
- Simultaneous requests in the same IDLE cycle are resolved by priority. Losers keep req high and are served in order.
- reset low mid-transaction: strobes released and ad_oe=0 asynchronously. No done pulse is generated and rdata returns to 0.
- TPH=1 is legal: each phase is one cycle, done at G+4.

## Configuration
- RTC_SCHED_RR_EN defined: init(0) stays highest priority. Requesters 1 and 2 round-robin: the one granted last among {1,2} has lower priority on the next arbitration. After reset, 2 has priority.
- Not defined: fixed priority 0 > 2 > 1, with no round-robin state register.

## Test plan
- Single write: TPH=2, req[2]=1, wr=1, addr=0x21, wdata=0x45 -> gnt=3'b100 next cycle. ADDR 2 cycles with ad_n=0, wr_n=0, ad_out=0x21. DATA drives 0x45 with wr_n=0. done[2] pulses 8 cycles after grant.
- Single read: req[1]=1, wr=0, addr=0x22, ad_in=0x37 during DATA -> rd_n=0 only in DATA, ad_oe=0 in DATA, rdata=0x37 with done[1].
- Contention: req=3'b111 in the same cycle -> grants 0, then 2, then 1 (fixed). With RTC_SCHED_RR_EN and 1,2 held continuously, grants alternate 2,1,2,1.
- Reset mid-op: assert reset low during DATA of a write -> cs_n/wr_n=1 and ad_oe=0 immediately. No done pulse, gnt=0, and the next request starts cleanly from IDLE.
- Request drop: deassert req[1] during AHOLD -> transaction completes and done[1] still pulses. No second grant follows.
- Protocol checker across all tests: never rd_n=0 and wr_n=0 together, never ad_oe=1 with rd_n=0, gnt always one-hot or zero.
